exception_unit: RTL and testbench
=================================

EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter N_IRQ, default 4: number of external interrupt channels, 1..8.
REQ-002 Parameter ESTATUS_W, default 4: EStatus width; 2**ESTATUS_W >= N_IRQ+2 SHALL be checked at elaboration.
REQ-003 Parameter TIMEOUT, default 16: acknowledge-wait limit in cycles, used only with EXC_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ExtIRQ  in  N_IRQ  level interrupt requests; bit 0 has highest priority.
REQ-007 IrqMask  in  N_IRQ  1 = channel enabled.
REQ-008 NotAnInstr  in  1  invalid-opcode flag from the main decoder.
REQ-009 ExcAck  in  1  the core accepts the current exception.
REQ-010 ERet  in  1  return-from-exception executed.
REQ-011 Exc  out  1  exception request to the core.
REQ-012 ExtIAck  out  N_IRQ  one-hot per-channel acknowledge.
REQ-013 EStatus  out  ESTATUS_W  cause code.
REQ-014 InHandler  out  1  handler active.
REQ-015 Pending  out  N_IRQ  latched pending bits.
REQ-016 TimeoutErr  out  1  one-cycle pulse; present only with EXC_TIMEOUT_EN.

Function
REQ-017 Pending[i] SHALL set on any edge where ExtIRQ[i]=1, regardless of mask or state.
REQ-018 Pending[i] SHALL clear on the edge where ExtIAck[i]=1; clear wins over simultaneous set.
REQ-019 FSM states: IDLE, PEND, HANDLER.
REQ-020 IDLE->PEND when NotAnInstr=1, or (Pending|ExtIRQ)&IrqMask is nonzero; Exc=1 from the next cycle (1-cycle latency).
REQ-021 Source selection on IDLE->PEND: NotAnInstr beats every IRQ; otherwise the lowest enabled index wins; the choice SHALL be latched and held until ERet.
REQ-022 EStatus encoding: 0 = none, 1 = invalid opcode, 2+i = IRQ channel i; registered; valid from PEND entry through HANDLER.
REQ-023 In PEND, Exc=1; ExcAck=1 moves PEND->HANDLER on that edge.
REQ-024 ExtIAck[i] SHALL be combinational: ExcAck & (state==PEND) & (latched source == channel i); zero for an invalid-opcode source.
REQ-025 In HANDLER: InHandler=1 and Exc=0; no new exception is taken (no nesting); incoming requests only latch into Pending.
REQ-026 ERet in HANDLER SHALL return to IDLE and set EStatus to 0; a surviving enabled pending bit SHALL re-enter PEND one cycle later.
REQ-027 ERet in IDLE or PEND, and ExcAck in IDLE or HANDLER, SHALL be ignored.
REQ-028 Masking a channel while it is the latched PEND source SHALL NOT cancel the exception.

Reset
REQ-029 reset=1 SHALL force IDLE with Exc=0, ExtIAck=0, EStatus=0, InHandler=0, Pending=0, TimeoutErr=0 and the timeout counter at 0, from any state, including mid-handshake.

Configuration
REQ-030 With EXC_TIMEOUT_EN defined, a counter SHALL run in PEND; after TIMEOUT cycles without ExcAck it SHALL pulse TimeoutErr for 1 cycle and return to IDLE with Pending unchanged.
REQ-031 Without EXC_TIMEOUT_EN, the TimeoutErr port and the counter SHALL be absent and PEND SHALL wait indefinitely.

Structure
REQ-032 Package exc_pkg SHALL hold the FSM state enum and the EStatus constants (ESTATUS_NONE, ESTATUS_INVOP, ESTATUS_IRQ_BASE).
REQ-033 Sub-module exc_prio_enc SHALL take an N_IRQ-bit vector and return a valid flag and the lowest set index.

Verification
REQ-034 ExtIRQ=4'b0100, IrqMask=4'hF -> next cycle Exc=1, EStatus=4; ExcAck -> ExtIAck=4'b0100 in the same cycle, Pending[2] cleared, InHandler=1.
REQ-035 NotAnInstr=1 and ExtIRQ=4'b0001 on the same edge -> EStatus=1, ExtIAck=0 on ack; after ERet, Exc=1 with EStatus=2 one cycle later.
REQ-036 ExtIRQ=4'b1000 with IrqMask=4'b0111 -> Pending=4'b1000, Exc stays 0; IrqMask=4'hF -> Exc=1, EStatus=5.
REQ-037 reset asserted in HANDLER with Pending=4'b0011 -> all outputs 0 the next cycle.
REQ-038 With EXC_TIMEOUT_EN and TIMEOUT=16: PEND with no ExcAck for 16 cycles -> TimeoutErr pulse, state IDLE, Pending retained, Exc re-asserted.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and cause-code constants for the exception unit.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_HANDLER = 2'd2
  } exc_state_e;

  localparam int ESTATUS_NONE     = 0;
  localparam int ESTATUS_INVOP    = 1;
  localparam int ESTATUS_IRQ_BASE = 2;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder over an N-bit request vector.
module exc_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest set bit is the last writer.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt sequencer: IDLE -> PEND -> HANDLER with latched cause.
// Optional acknowledge timeout enabled by defining EXC_TIMEOUT_EN.
module exception_unit
  import exc_pkg::*;
#(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     ExtIRQ,
  input  logic [N_IRQ-1:0]     IrqMask,
  input  logic                 NotAnInstr,
  input  logic                 ExcAck,
  input  logic                 ERet,
  output logic                 Exc,
  output logic [N_IRQ-1:0]     ExtIAck,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic                 InHandler,
  output logic [N_IRQ-1:0]     Pending
`ifdef EXC_TIMEOUT_EN
  ,
  output logic                 TimeoutErr
`endif
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  if (N_IRQ < 1 || N_IRQ > 8) begin : g_bad_nirq
    $error("exception_unit: N_IRQ must be 1..8");
  end
  if ((2 ** ESTATUS_W) < N_IRQ + 2) begin : g_bad_esw
    $error("exception_unit: ESTATUS_W too narrow for N_IRQ+2 codes");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("exception_unit: TIMEOUT must be >= 1");
  end

  exc_state_e           state_q;
  logic [ESTATUS_W-1:0] estatus_q;
  logic [N_IRQ-1:0]     pending_q, pending_d;
  logic [N_IRQ-1:0]     req_vec;
  logic                 req_vld;
  logic [IDX_W-1:0]     req_idx;

  assign req_vec = (pending_q | ExtIRQ) & IrqMask;

  exc_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_prio (
    .vec_i  (req_vec),
    .valid_o(req_vld),
    .idx_o  (req_idx)
  );

  // Ack targets only the latched IRQ cause; an invalid-opcode cause never matches.
  always_comb begin
    ExtIAck = '0;
    for (int i = 0; i < N_IRQ; i++)
      ExtIAck[i] = ExcAck && (state_q == ST_PEND) &&
                   (estatus_q == ESTATUS_W'(ESTATUS_IRQ_BASE + i));
  end

  assign pending_d = (pending_q | ExtIRQ) & ~ExtIAck;

`ifdef EXC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             terr_q;
  assign TimeoutErr = terr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      estatus_q <= '0;
      pending_q <= '0;
`ifdef EXC_TIMEOUT_EN
      cnt_q     <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      pending_q <= pending_d;
`ifdef EXC_TIMEOUT_EN
      terr_q    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
`ifdef EXC_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (NotAnInstr) begin
            state_q   <= ST_PEND;
            estatus_q <= ESTATUS_W'(ESTATUS_INVOP);
          end else if (req_vld) begin
            state_q   <= ST_PEND;
            estatus_q <= ESTATUS_W'(ESTATUS_IRQ_BASE) + ESTATUS_W'(req_idx);
          end
        end
        ST_PEND: begin
          if (ExcAck) begin
            state_q <= ST_HANDLER;
          end
`ifdef EXC_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= ST_IDLE;
            estatus_q <= ESTATUS_W'(ESTATUS_NONE);
            terr_q    <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_HANDLER: begin
          if (ERet) begin
            state_q   <= ST_IDLE;
            estatus_q <= ESTATUS_W'(ESTATUS_NONE);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          estatus_q <= '0;
        end
      endcase
    end
  end

  assign Exc       = (state_q == ST_PEND);
  assign InHandler = (state_q == ST_HANDLER);
  assign EStatus   = estatus_q;
  assign Pending   = pending_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit (default parameters).
module tb_exception_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ExtIRQ, IrqMask;
  logic       NotAnInstr, ExcAck, ERet;
  logic       Exc, InHandler;
  logic [3:0] ExtIAck, EStatus, Pending;
`ifdef EXC_TIMEOUT_EN
  logic       TimeoutErr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ExtIRQ    (ExtIRQ),
    .IrqMask   (IrqMask),
    .NotAnInstr(NotAnInstr),
    .ExcAck    (ExcAck),
    .ERet      (ERet),
    .Exc       (Exc),
    .ExtIAck   (ExtIAck),
    .EStatus   (EStatus),
    .InHandler (InHandler),
    .Pending   (Pending)
`ifdef EXC_TIMEOUT_EN
    ,
    .TimeoutErr(TimeoutErr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are examined 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ExtIRQ = '0; IrqMask = '0;
    NotAnInstr = 1'b0; ExcAck = 1'b0; ERet = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_exc", 32'(Exc), 0);
    chk("rst_est", 32'(EStatus), 0);
    chk("rst_inh", 32'(InHandler), 0);
    chk("rst_pend", 32'(Pending), 0);

    // ExcAck / ERet in IDLE are ignored
    ExcAck = 1'b1; ERet = 1'b1; #1;
    chk("idle_ack", 32'(ExtIAck), 0);
    step();
    ExcAck = 1'b0; ERet = 1'b0;
    chk("idle_exc", 32'(Exc), 0);

    // single IRQ on channel 2
    IrqMask = 4'hF; ExtIRQ = 4'b0100;
    step();
    ExtIRQ = '0;
    chk("irq2_exc", 32'(Exc), 1);
    chk("irq2_est", 32'(EStatus), 4);
    chk("irq2_pend", 32'(Pending), 4'b0100);
    ExcAck = 1'b1; #1;
    chk("irq2_iack", 32'(ExtIAck), 4'b0100);
    step();
    ExcAck = 1'b0;
    chk("irq2_inh", 32'(InHandler), 1);
    chk("irq2_hexc", 32'(Exc), 0);
    chk("irq2_clr", 32'(Pending), 0);
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("eret_est", 32'(EStatus), 0);
    chk("eret_inh", 32'(InHandler), 0);
    step();
    chk("idle_quiet", 32'(Exc), 0);

    // invalid opcode beats simultaneous IRQ0
    NotAnInstr = 1'b1; ExtIRQ = 4'b0001;
    step();
    NotAnInstr = 1'b0; ExtIRQ = '0;
    chk("inv_est", 32'(EStatus), 1);
    chk("inv_exc", 32'(Exc), 1);
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("pend_eret_ign", 32'(Exc), 1);
    ExcAck = 1'b1; #1;
    chk("inv_iack", 32'(ExtIAck), 0);
    step();
    ExcAck = 1'b0;
    chk("inv_inh", 32'(InHandler), 1);
    chk("inv_pend", 32'(Pending), 4'b0001);
    // new request during handler only latches
    ExtIRQ = 4'b0010;
    step();
    ExtIRQ = '0;
    chk("nonest_exc", 32'(Exc), 0);
    chk("nonest_pend", 32'(Pending), 4'b0011);
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("ret_idle", 32'(Exc), 0);
    step();
    chk("reent_exc", 32'(Exc), 1);
    chk("reent_est", 32'(EStatus), 2);
    ExcAck = 1'b1; #1;
    chk("ch0_iack", 32'(ExtIAck), 4'b0001);
    step();
    ExcAck = 1'b0; ERet = 1'b1;
    step();
    ERet = 1'b0;
    step();
    chk("ch1_est", 32'(EStatus), 3);
    ExcAck = 1'b1; #1;
    chk("ch1_iack", 32'(ExtIAck), 4'b0010);
    step();
    ExcAck = 1'b0; ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("drain_pend", 32'(Pending), 0);

    // masked channel latches but does not raise Exc
    IrqMask = 4'b0111; ExtIRQ = 4'b1000;
    step();
    ExtIRQ = '0;
    chk("mask_pend", 32'(Pending), 4'b1000);
    chk("mask_exc0", 32'(Exc), 0);
    step();
    chk("mask_exc1", 32'(Exc), 0);
    IrqMask = 4'hF;
    step();
    chk("unmask_exc", 32'(Exc), 1);
    chk("unmask_est", 32'(EStatus), 5);
    // masking the latched source does not cancel it
    IrqMask = '0;
    step();
    chk("remask_exc", 32'(Exc), 1);
    chk("remask_est", 32'(EStatus), 5);
    ExcAck = 1'b1; #1;
    chk("ch3_iack", 32'(ExtIAck), 4'b1000);
    step();
    ExcAck = 1'b0; IrqMask = 4'hF;

    // reset from HANDLER with pending bits
    ExtIRQ = 4'b0011;
    step();
    ExtIRQ = '0;
    chk("h_pend", 32'(Pending), 4'b0011);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("hr_exc", 32'(Exc), 0);
    chk("hr_inh", 32'(InHandler), 0);
    chk("hr_est", 32'(EStatus), 0);
    chk("hr_pend", 32'(Pending), 0);
    chk("hr_iack", 32'(ExtIAck), 0);

`ifdef EXC_TIMEOUT_EN
    chk("hr_terr", 32'(TimeoutErr), 0);
    ExtIRQ = 4'b0001;
    step();
    ExtIRQ = '0;
    chk("to_enter", 32'(Exc), 1);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("to_wait_exc", 32'(Exc), 1);
      chk("to_wait_err", 32'(TimeoutErr), 0);
    end
    step();
    chk("to_pulse", 32'(TimeoutErr), 1);
    chk("to_idle", 32'(Exc), 0);
    chk("to_pend", 32'(Pending), 4'b0001);
    step();
    chk("to_pulse_end", 32'(TimeoutErr), 0);
    chk("to_reexc", 32'(Exc), 1);
`else
    // without the timeout PEND waits indefinitely
    ExtIRQ = 4'b0001;
    step();
    ExtIRQ = '0;
    for (int k = 0; k < 40; k++) step();
    chk("no_to_exc", 32'(Exc), 1);
    chk("no_to_est", 32'(EStatus), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
